periph_bus_master: RTL and testbench

- Initiator side of the peripheral bus: converts a valid/ready command stream (address, write data, read/write) into single-cycle select/write strobes on the peripheral address/data bus.
- Captures read data after a fixed latency and returns one response per command on a valid/ready response stream.
- Sits between the core or a test driver and the peripheral block, driving the peripheral's address, data, select and write inputs and sampling its data output and interrupt.

---
 rtl/periph_bus_master.sv | 222 ++++++++++++++++++++++
 tb/tb_periph_bus_master.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/periph_bus_master.sv
// periph_bus_master
// Initiator side of the peripheral bus. It accepts one command at a time on a
// valid/ready stream and turns it into a single-cycle select (and write)
// strobe on the peripheral address/data bus. For reads it samples the
// peripheral data READ_LATENCY cycles after the select cycle. It returns one
// response per command on a valid/ready stream.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   cmd_valid_i/ready_o     command handshake
//   cmd_addr_i/data_i/wr_i  command payload (wr=1 write, wr=0 read)
//   rsp_valid_o/ready_i     response handshake
//   rsp_data_o, rsp_wr_o    read data (0 for writes), echo of command type
//   addr_o, data_o          peripheral address/data (hold value when idle)
//   sel_o, wr_o             one-cycle select / write strobes
//   data_i, irq_i           peripheral read data and interrupt
//   busy_o                  high while a command is in flight
//
// Optional build macro PERIPH_BUS_MASTER_IRQ_CAPTURE_EN adds irq_pending_o and
// irq_ack_i. In that build a rising edge of the registered irq_i sets a sticky
// pending bit, and irq_ack_i clears it. When a set and an ack arrive together,
// the set wins.

module periph_bus_master #(
  parameter int ADDR_WIDTH       = 32,
  parameter int MEMORY_BUS_WIDTH = 32,
  parameter int READ_LATENCY     = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        cmd_valid_i,
  output logic                        cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]       cmd_addr_i,
  input  logic [MEMORY_BUS_WIDTH-1:0] cmd_data_i,
  input  logic                        cmd_wr_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [MEMORY_BUS_WIDTH-1:0] rsp_data_o,
  output logic                        rsp_wr_o,
  output logic [ADDR_WIDTH-1:0]       addr_o,
  output logic [MEMORY_BUS_WIDTH-1:0] data_o,
  output logic                        sel_o,
  output logic                        wr_o,
  input  logic [MEMORY_BUS_WIDTH-1:0] data_i,
  input  logic                        irq_i,
  output logic                        busy_o
`ifdef PERIPH_BUS_MASTER_IRQ_CAPTURE_EN
  ,
  output logic                        irq_pending_o,
  input  logic                        irq_ack_i
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // WAIT counts down from READ_LATENCY-1 to 0. The sample happens on the cycle
  // the counter reads 0.
  localparam logic [3:0] RL_LOAD = 4'(READ_LATENCY - 1);

  state_e                      state_q, state_d;
  logic [3:0]                  cnt_q, cnt_d;
  logic                        cmd_wr_q, cmd_wr_d;
  logic                        cmd_ready_q, cmd_ready_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic [MEMORY_BUS_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                        rsp_wr_q, rsp_wr_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic [MEMORY_BUS_WIDTH-1:0] data_q, data_d;
  logic                        sel_q, sel_d;
  logic                        wr_q, wr_d;
  logic                        busy_q, busy_d;

  // Next-state and next-output logic of the transfer FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_wr_d   = cmd_wr_q;
    rsp_data_d = rsp_data_q;
    rsp_wr_d   = rsp_wr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    sel_d      = 1'b0;
    wr_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          // The strobes are registered here, so they appear during ACCESS only.
          addr_d   = cmd_addr_i;
          data_d   = cmd_data_i;
          cmd_wr_d = cmd_wr_i;
          sel_d    = 1'b1;
          wr_d     = cmd_wr_i;
          state_d  = ST_ACCESS;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (cmd_wr_q) begin
          rsp_data_d = {MEMORY_BUS_WIDTH{1'b0}};
          rsp_wr_d   = 1'b1;
          state_d    = ST_RESP;
        end else begin
          cnt_d      = RL_LOAD;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          rsp_data_d = data_i;
          rsp_wr_d   = 1'b0;
          state_d    = ST_RESP;
        end else begin
          cnt_d      = cnt_q - 4'd1;
          state_d    = ST_WAIT;
        end
      end
      ST_RESP: begin
        // rsp_valid_o is high for the whole of RESP, so ready alone completes it.
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // These handshake and status outputs are registered and follow the next state.
    cmd_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and output registers, with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      cmd_wr_q    <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= {MEMORY_BUS_WIDTH{1'b0}};
      rsp_wr_q    <= 1'b0;
      addr_q      <= {ADDR_WIDTH{1'b0}};
      data_q      <= {MEMORY_BUS_WIDTH{1'b0}};
      sel_q       <= 1'b0;
      wr_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_wr_q    <= rsp_wr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      sel_q       <= sel_d;
      wr_q        <= wr_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_wr_o    = rsp_wr_q;
  assign addr_o      = addr_q;
  assign data_o      = data_q;
  assign sel_o       = sel_q;
  assign wr_o        = wr_q;
  assign busy_o      = busy_q;

`ifdef PERIPH_BUS_MASTER_IRQ_CAPTURE_EN
  logic irq_q, irq_d;
  logic irq_prev_q, irq_prev_d;
  logic irq_pending_q, irq_pending_d;

  // Edge detection on the registered interrupt, and the sticky pending bit.
  always_comb begin
    irq_d      = irq_i;
    irq_prev_d = irq_q;
    if (irq_q && !irq_prev_q) begin
      irq_pending_d = 1'b1;
    end else if (irq_ack_i) begin
      irq_pending_d = 1'b0;
    end else begin
      irq_pending_d = irq_pending_q;
    end
  end

  // Interrupt capture registers, with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_q         <= 1'b0;
      irq_prev_q    <= 1'b0;
      irq_pending_q <= 1'b0;
    end else begin
      irq_q         <= irq_d;
      irq_prev_q    <= irq_prev_d;
      irq_pending_q <= irq_pending_d;
    end
  end

  assign irq_pending_o = irq_pending_q;
`else
  // The interrupt input is intentionally not used in this build.
  logic unused_irq_s;
  assign unused_irq_s = irq_i;
`endif

endmodule

// File: tb/tb_periph_bus_master.sv
// tb_periph_bus_master
// Runs two instances side by side, with READ_LATENCY 1 (index 0) and 3
// (index 1). Both see the same inputs. A transaction-level model predicts
// every output on every cycle. Directed sequences add literal expectations.
module tb_periph_bus_master;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i, cmd_valid_i, cmd_wr_i, rsp_ready_i, irq_i;
  logic [AW-1:0] cmd_addr_i;
  logic [DW-1:0] cmd_data_i, data_i;
  logic [1:0]    cmd_ready_w, rsp_valid_w, rsp_wr_w, sel_w, wr_w, busy_w;
  logic [DW-1:0] rsp_data_w [2];
  logic [AW-1:0] addr_w [2];
  logic [DW-1:0] data_w [2];
`ifdef PERIPH_BUS_MASTER_IRQ_CAPTURE_EN
  logic [1:0]    irq_pend_w;
  logic          irq_ack_i;
`endif

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    periph_bus_master #(
      .ADDR_WIDTH(AW), .MEMORY_BUS_WIDTH(DW), .READ_LATENCY((g == 0) ? 1 : 3)
    ) u_dut (
      .clk_i(clk), .rst_i(rst_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_w[g]),
      .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i), .cmd_wr_i(cmd_wr_i),
      .rsp_valid_o(rsp_valid_w[g]), .rsp_ready_i(rsp_ready_i),
      .rsp_data_o(rsp_data_w[g]), .rsp_wr_o(rsp_wr_w[g]),
      .addr_o(addr_w[g]), .data_o(data_w[g]), .sel_o(sel_w[g]), .wr_o(wr_w[g]),
      .data_i(data_i), .irq_i(irq_i), .busy_o(busy_w[g])
`ifdef PERIPH_BUS_MASTER_IRQ_CAPTURE_EN
      , .irq_pending_o(irq_pend_w[g]), .irq_ack_i(irq_ack_i)
`endif
    );
  end

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h want=%0h at %0t", name, i, act, exp, $time);
    end
  endtask

  // ---------------- transaction model + per-cycle compare ----------------
  int          rl [2] = '{1, 3};
  bit          m_busy [2], m_resp [2], m_wr [2], m_rwr [2], e_sel [2];
  int          m_n [2];
  logic [31:0] m_addr [2], m_data [2], m_rdata [2];
  bit          m_init = 1'b0;
  int          edge_i = 0;
  bit          h1 = 1'b0, h2 = 1'b0, m_pend = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (m_init) begin
        for (int i = 0; i < 2; i++) begin
          chk("cmd_ready", i, 32'(cmd_ready_w[i]), 32'(!m_busy[i]));
          chk("rsp_valid", i, 32'(rsp_valid_w[i]), 32'(m_resp[i]));
          chk("busy", i, 32'(busy_w[i]), 32'(m_busy[i]));
          chk("sel", i, 32'(sel_w[i]), 32'(e_sel[i]));
          chk("wr", i, 32'(wr_w[i]), 32'(e_sel[i] & m_wr[i]));
          chk("addr", i, addr_w[i], m_addr[i]);
          chk("data", i, data_w[i], m_data[i]);
          chk("rsp_data", i, rsp_data_w[i], m_rdata[i]);
          chk("rsp_wr", i, 32'(rsp_wr_w[i]), 32'(m_rwr[i]));
`ifdef PERIPH_BUS_MASTER_IRQ_CAPTURE_EN
          chk("irq_pending", i, 32'(irq_pend_w[i]), 32'(m_pend));
`endif
        end
      end
      // Inputs are now stable. Predict the outputs that follow the next edge.
      edge_i++;
      if (rst_i) begin
        m_init = 1'b1;
        h1 = 1'b0; h2 = 1'b0; m_pend = 1'b0;
        for (int i = 0; i < 2; i++) begin
          m_busy[i] = 1'b0; m_resp[i] = 1'b0; e_sel[i] = 1'b0; m_wr[i] = 1'b0;
          m_rwr[i] = 1'b0; m_addr[i] = 32'h0; m_data[i] = 32'h0; m_rdata[i] = 32'h0;
        end
      end else if (m_init) begin
        for (int i = 0; i < 2; i++) begin
          e_sel[i] = 1'b0;
          if (!m_busy[i]) begin
            if (cmd_valid_i) begin
              m_busy[i] = 1'b1; m_n[i] = edge_i; m_wr[i] = cmd_wr_i;
              m_addr[i] = cmd_addr_i; m_data[i] = cmd_data_i; e_sel[i] = 1'b1;
            end
          end else if (m_resp[i]) begin
            if (rsp_ready_i) begin
              m_busy[i] = 1'b0; m_resp[i] = 1'b0;
            end
          end else if (m_wr[i] && (edge_i - m_n[i] == 1)) begin
            m_resp[i] = 1'b1; m_rdata[i] = 32'h0; m_rwr[i] = 1'b1;
          end else if (!m_wr[i] && (edge_i - m_n[i] == 1 + rl[i])) begin
            m_resp[i] = 1'b1; m_rdata[i] = data_i; m_rwr[i] = 1'b0;
          end
        end
`ifdef PERIPH_BUS_MASTER_IRQ_CAPTURE_EN
        if (h1 && !h2) m_pend = 1'b1;
        else if (irq_ack_i) m_pend = 1'b0;
`endif
        h2 = h1; h1 = irq_i;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus(input int n);
    cmd_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    repeat (n) tick();
  endtask

  // Read that is checked on the READ_LATENCY=3 instance. Only cycle N+4
  // carries val; every other cycle carries random data.
  task automatic read3(input logic [31:0] addr, input logic [31:0] val);
    cmd_valid_i = 1'b1; cmd_wr_i = 1'b0; cmd_addr_i = addr; rsp_ready_i = 1'b1;
    tick();                                   // cycle N+1
    chk("rd3_sel", 1, 32'(sel_w[1]), 32'h1);
    chk("rd3_wr", 1, 32'(wr_w[1]), 32'h0);
    cmd_valid_i = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      data_i = $urandom;
      tick();
    end                                       // now cycle N+4
    data_i = val;
    chk("rd3_early", 1, 32'(rsp_valid_w[1]), 32'h0);
    tick();                                   // cycle N+5
    data_i = $urandom;
    chk("rd3_valid", 1, 32'(rsp_valid_w[1]), 32'h1);
    chk("rd3_data", 1, rsp_data_w[1], val);
  endtask

  logic [31:0] drv [6];

  initial begin
    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_wr_i = 1'b0; rsp_ready_i = 1'b0;
    cmd_addr_i = 32'h0; cmd_data_i = 32'h0; data_i = 32'h0; irq_i = 1'b0;
`ifdef PERIPH_BUS_MASTER_IRQ_CAPTURE_EN
    irq_ack_i = 1'b0;
`endif
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", i, 32'(cmd_ready_w[i]), 32'h1);
      chk("rst_valid", i, 32'(rsp_valid_w[i]), 32'h0);
      chk("rst_sel", i, 32'(sel_w[i]), 32'h0);
      chk("rst_addr", i, addr_w[i], 32'h0);
    end
    rst_i = 1'b0;

    // 1: single write
    cmd_valid_i = 1'b1; cmd_wr_i = 1'b1; cmd_addr_i = 32'hF0000010;
    cmd_data_i = 32'h000000A5; rsp_ready_i = 1'b1;
    tick();
    chk("wr_sel", 0, 32'(sel_w[0]), 32'h1);
    chk("wr_wr", 0, 32'(wr_w[0]), 32'h1);
    chk("wr_addr", 0, addr_w[0], 32'hF0000010);
    chk("wr_data", 0, data_w[0], 32'h000000A5);
    cmd_valid_i = 1'b0;
    tick();
    chk("wr_sel_off", 0, 32'(sel_w[0]), 32'h0);
    chk("wr_rsp_valid", 0, 32'(rsp_valid_w[0]), 32'h1);
    chk("wr_rsp_wr", 0, 32'(rsp_wr_w[0]), 32'h1);
    chk("wr_rsp_data", 0, rsp_data_w[0], 32'h0);
    idle_bus(2);

    // 2: read on the READ_LATENCY=1 instance
    cmd_valid_i = 1'b1; cmd_wr_i = 1'b0; cmd_addr_i = 32'hF0000020;
    tick();                                   // N+1
    chk("rd1_sel", 0, 32'(sel_w[0]), 32'h1);
    chk("rd1_wr", 0, 32'(wr_w[0]), 32'h0);
    chk("rd1_addr", 0, addr_w[0], 32'hF0000020);
    cmd_valid_i = 1'b0; data_i = $urandom;
    tick();                                   // N+2
    data_i = 32'h12345678;
    chk("rd1_early", 0, 32'(rsp_valid_w[0]), 32'h0);
    tick();                                   // N+3
    data_i = $urandom;
    chk("rd1_valid", 0, 32'(rsp_valid_w[0]), 32'h1);
    chk("rd1_data", 0, rsp_data_w[0], 32'h12345678);
    idle_bus(6);

    // 3: read on the READ_LATENCY=3 instance
    read3(32'hF0000030, 32'hCAFEF00D);
    idle_bus(4);

    // 4: response backpressure
    cmd_valid_i = 1'b1; cmd_wr_i = 1'b0; cmd_addr_i = 32'hF0000040; rsp_ready_i = 1'b0;
    tick();
    cmd_valid_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      data_i = $urandom; drv[k] = data_i;
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      cmd_valid_i = k[0]; cmd_addr_i = $urandom; cmd_wr_i = $urandom_range(0, 1) == 1;
      data_i = $urandom;
      for (int i = 0; i < 2; i++) begin
        chk("bp_ready", i, 32'(cmd_ready_w[i]), 32'h0);
        chk("bp_sel", i, 32'(sel_w[i]), 32'h0);
        chk("bp_valid", i, 32'(rsp_valid_w[i]), 32'h1);
      end
      chk("bp_data", 0, rsp_data_w[0], drv[2]);
      chk("bp_data", 1, rsp_data_w[1], drv[4]);
      tick();
    end
    cmd_valid_i = 1'b0; rsp_ready_i = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("bp_release_ready", i, 32'(cmd_ready_w[i]), 32'h1);
      chk("bp_release_valid", i, 32'(rsp_valid_w[i]), 32'h0);
    end
    idle_bus(2);

    // 5: reset during WAIT of the READ_LATENCY=3 instance
    cmd_valid_i = 1'b1; cmd_wr_i = 1'b0; cmd_addr_i = 32'hF0000050;
    tick();                                   // N+1
    cmd_valid_i = 1'b0;
    tick();                                   // N+2, in WAIT
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rst_mid_sel", 1, 32'(sel_w[1]), 32'h0);
    chk("rst_mid_ready", 1, 32'(cmd_ready_w[1]), 32'h1);
    chk("rst_mid_busy", 1, 32'(busy_w[1]), 32'h0);
    for (int k = 0; k < 6; k++) begin
      chk("rst_mid_novalid", 1, 32'(rsp_valid_w[1]), 32'h0);
      tick();
    end
    read3(32'hF0000060, 32'h5A5A0001);
    idle_bus(4);

`ifdef PERIPH_BUS_MASTER_IRQ_CAPTURE_EN
    // 6: interrupt capture
    irq_i = 1'b1;
    tick();
    irq_i = 1'b0;
    chk("irq_not_yet", 0, 32'(irq_pend_w[0]), 32'h0);
    tick();
    chk("irq_set", 0, 32'(irq_pend_w[0]), 32'h1);
    repeat (3) tick();
    chk("irq_sticky", 0, 32'(irq_pend_w[0]), 32'h1);
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    chk("irq_ack", 0, 32'(irq_pend_w[0]), 32'h0);
    irq_i = 1'b1;
    tick();
    irq_i = 1'b0; irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    chk("irq_set_wins", 0, 32'(irq_pend_w[0]), 32'h1);
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
`endif

    // Random traffic, with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      rst_i       = ($urandom_range(0, 299) == 0);
      cmd_valid_i = $urandom_range(0, 1) == 1;
      cmd_wr_i    = $urandom_range(0, 1) == 1;
      cmd_addr_i  = $urandom;
      cmd_data_i  = $urandom;
      rsp_ready_i = $urandom_range(0, 3) != 0;
      data_i      = $urandom;
      irq_i       = $urandom_range(0, 3) == 0;
`ifdef PERIPH_BUS_MASTER_IRQ_CAPTURE_EN
      irq_ack_i   = $urandom_range(0, 7) == 0;
`endif
      tick();
    end
    rst_i = 1'b0;
    idle_bus(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
